// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq_pkg
//  Description : Shared opcodes, FSM state encodings, inst-word bit positions
//                and small helpers for the core command sequencer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    // Host command opcodes; 5..7 are rejected as illegal.
    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LOAD_K   = 3'd1;
    localparam logic [2:0] OP_LOAD_Q   = 3'd2;
    localparam logic [2:0] OP_EXEC     = 3'd3;
    localparam logic [2:0] OP_READ_OUT = 3'd4;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // inst word layout towards the core
    localparam int INST_W         = 20;
    localparam int INST_LOADK_BIT = 19;
    localparam int INST_LOADQ_BIT = 18;
    localparam int INST_EXEC_BIT  = 17;
    localparam int INST_RDOUT_BIT = 16;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_READ_OUT);
    endfunction

    // One-hot strobe mask for the inst word; NOP/illegal map to no strobe.
    function automatic logic [INST_W-1:0] op_mask(input logic [2:0] op);
        logic [INST_W-1:0] m;
        m = '0;
        case (op)
            OP_LOAD_K:   m[INST_LOADK_BIT] = 1'b1;
            OP_LOAD_Q:   m[INST_LOADQ_BIT] = 1'b1;
            OP_EXEC:     m[INST_EXEC_BIT]  = 1'b1;
            OP_READ_OUT: m[INST_RDOUT_BIT] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage : core_seq_pkg
`default_nettype wire

// File: rtl/seq_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_beat_counter
//  Description : Burst address/length tracker. Loads a start address and a
//                beat count, then on each step increments the address (wrap
//                modulo 2^ADDR_W) and decrements the remaining count.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_load        - load i_addr / i_len
//                i_addr, i_len - burst start address and length
//                i_step        - one beat issued this cycle
//                o_addr        - address of the beat to issue next
//                o_last        - the next beat is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_beat_counter #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_remain, w_remain_nxt;

    always_comb begin
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        if (i_load) begin
            w_addr_nxt   = i_addr;
            w_remain_nxt = i_len;
        end else if (i_step) begin
            // Natural overflow of the ADDR_W-bit sum gives the wrap to 0.
            w_addr_nxt   = r_addr + ADDR_W'(1);
            w_remain_nxt = r_remain - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else begin
            r_addr   <= w_addr_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remain == LEN_W'(1));

endmodule : seq_beat_counter
`default_nettype wire

// File: rtl/core_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_cmd_sequencer
//  Description : Expands host burst commands and data beats into the
//                per-cycle inst word and mem_in bus consumed by the core.
//                The core cannot stall, so every output here is registered
//                and this block fully owns inst/mem_in timing.
//  Ports       : clk, reset            - clock, asynchronous active-high reset
//                cmd_valid/cmd_ready   - command handshake
//                cmd_op/addr/len       - opcode, start address, beat count
//                dat_valid/dat_ready   - data beat handshake (LOAD_K/LOAD_Q)
//                dat_in                - data beat
//                inst, mem_in          - registered outputs to the core
//                busy                  - burst in progress
//                done, err             - single-cycle completion / illegal-op
//  Revision    : 1.0 - initial release
// ============================================================================
module core_cmd_sequencer
    import core_seq_pkg::*;
#(
    parameter int BW     = 8,
    parameter int PR     = 16,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                dat_valid,
    output logic                dat_ready,
    input  logic [PR*BW-1:0]    dat_in,
    output logic [INST_W-1:0]   inst,
    output logic [PR*BW-1:0]    mem_in,
    output logic                busy,
    output logic                done,
    output logic                err
);

    logic [1:0]          r_state, w_state_nxt;
    logic [INST_W-1:0]   r_mask, w_mask_nxt;
    logic [INST_W-1:0]   r_inst, w_inst_nxt;
    logic [PR*BW-1:0]    r_mem_in, w_mem_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;

    logic                w_cmd_fire;
    logic                w_cnt_load;
    logic                w_cnt_step;
    logic                w_cnt_last;
    logic [ADDR_W-1:0]   w_cnt_addr;
    logic [INST_W-1:0]   w_beat_inst;

    // cmd_ready is forced low while reset is held, not just after it.
    assign cmd_ready   = (r_state == ST_IDLE) && !reset;
    assign dat_ready   = (r_state == ST_DATA);
    assign busy        = (r_state != ST_IDLE);
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_beat_inst = r_mask | INST_W'(w_cnt_addr);

    seq_beat_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_counter (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_cnt_load),
        .i_addr (cmd_addr),
        .i_len  (cmd_len),
        .i_step (w_cnt_step),
        .o_addr (w_cnt_addr),
        .o_last (w_cnt_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_inst_nxt  = '0;          // bubble unless a beat is issued
        w_mem_nxt   = r_mem_in;    // mem_in only changes on a data beat
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_step  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (!op_is_legal(cmd_op)) begin
                        w_err_nxt = 1'b1;
                    end else if ((cmd_op == OP_NOP) || (cmd_len == '0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_cnt_load  = 1'b1;
                        w_mask_nxt  = op_mask(cmd_op);
                        w_state_nxt = ((cmd_op == OP_LOAD_K) || (cmd_op == OP_LOAD_Q))
                                      ? ST_DATA : ST_RUN;
                    end
                end
            end

            ST_DATA: begin
                if (dat_valid) begin
                    w_inst_nxt = w_beat_inst;
                    w_mem_nxt  = dat_in;
                    w_cnt_step = 1'b1;
                    if (w_cnt_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                w_inst_nxt = w_beat_inst;
                w_cnt_step = 1'b1;
                if (w_cnt_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_inst   <= '0;
            r_mem_in <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_inst   <= w_inst_nxt;
            r_mem_in <= w_mem_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign inst   = r_inst;
    assign mem_in = r_mem_in;
    assign done   = r_done;
    assign err    = r_err;

endmodule : core_cmd_sequencer
`default_nettype wire

// File: tb/tb_core_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_cmd_sequencer
//  Description : Scoreboard bench for core_cmd_sequencer. Stimulus tasks push
//                expected inst/mem_in beats and done/err events into a queue;
//                a monitor pops and compares whenever the DUT presents one.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_cmd_sequencer;

    localparam int BW     = 8;
    localparam int PR     = 16;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 8;
    localparam int DW     = BW * PR;

    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              dat_valid = 1'b0;
    logic              dat_ready;
    logic [DW-1:0]     dat_in = '0;
    logic [19:0]       inst;
    logic [DW-1:0]     mem_in;
    logic              busy;
    logic              done;
    logic              err;

    core_cmd_sequencer #(
        .BW(BW), .PR(PR), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
        .inst(inst), .mem_in(mem_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        logic [19:0]   inst;
        logic [DW-1:0] mem;
    } exp_t;

    exp_t          q[$];
    logic [19:0]   trace[$];
    logic          trace_en = 1'b0;
    logic [DW-1:0] exp_mem = '0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_beat(input logic [19:0] i, input logic [DW-1:0] m);
        exp_t e;
        e.kind = K_BEAT; e.inst = i; e.mem = m;
        q.push_back(e);
    endtask

    task automatic push_evt(input int k);
        exp_t e;
        e.kind = k; e.inst = '0; e.mem = '0;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (trace_en) trace.push_back(inst);
            if (inst != 20'h0) begin
                if (q.size() == 0) chk("unexpected_inst", DW'(inst), '0);
                else begin
                    mon_e = q.pop_front();
                    chk("beat_order", DW'(mon_e.kind), DW'(K_BEAT));
                    chk("inst", DW'(inst), DW'(mon_e.inst));
                    chk("mem_in", mem_in, mon_e.mem);
                end
            end
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", DW'(1), '0);
                else begin
                    mon_e = q.pop_front();
                    chk("done_order", DW'(mon_e.kind), DW'(K_DONE));
                end
            end
            if (err) begin
                if (q.size() == 0) chk("unexpected_err", DW'(1), '0);
                else begin
                    mon_e = q.pop_front();
                    chk("err_order", DW'(mon_e.kind), DW'(K_ERR));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", '0, DW'(1));
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    // Drives beats following a valid pattern; expectations are pushed only
    // for beats that will be accepted at the coming edge.
    task automatic data_phase(input logic [19:0] mask, input logic [ADDR_W-1:0] a0,
                              input int len, input logic [7:0] pat, input int plen);
        int left = len;
        int cyc = 0;
        logic [ADDR_W-1:0] a = a0;
        while (left > 0 && cyc < 100) begin
            dat_valid = pat[cyc % plen];
            dat_in    = {4{32'hC0DE0000 + 32'(a) * 32'h100 + 32'(cyc)}};
            if (dat_valid && dat_ready) begin
                push_beat(mask | 20'(a), dat_in);
                exp_mem = dat_in;
                a++;
                left--;
                if (left == 0) push_evt(K_DONE);
            end
            @(posedge clk); #1;
            cyc++;
        end
        dat_valid = 1'b0;
        if (left != 0) chk("data_phase_timeout", DW'(left), '0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [19:0] mask,
                           input logic [ADDR_W-1:0] a0, input int len);
        logic [ADDR_W-1:0] a = a0;
        for (int i = 0; i < len; i++) begin
            push_beat(mask | 20'(a), exp_mem);
            a++;
        end
        push_evt(K_DONE);
        send_cmd(op, a0, LEN_W'(len));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("queue_drain", DW'(q.size()), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int busy_cnt;
        int n;
        int last_k;
        int first_e;

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst", DW'(inst), '0);
        chk("rst_mem_in", mem_in, '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_cmd_ready", DW'(cmd_ready), '0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("idle_cmd_ready", DW'(cmd_ready), DW'(1));

        // LOAD_K addr 0x010 len 4, data steady
        send_cmd(3'd1, 11'h010, 8'd4);
        chk("data_busy", DW'(busy), DW'(1));
        data_phase(20'h80000, 11'h010, 4, 8'hFF, 1);
        wait_drain();

        // LOAD_Q len 3 with valid toggling 1,0,1,0,1
        send_cmd(3'd2, 11'h100, 8'd3);
        data_phase(20'h40000, 11'h100, 3, 8'b0001_0101, 5);
        wait_drain();

        // EXEC crossing the address wrap
        run_cmd(3'd3, 20'h20000, 11'h7FE, 3);
        busy_cnt = 0;
        while (busy && busy_cnt < 20) begin
            busy_cnt++;
            @(posedge clk); #1;
        end
        chk("exec_busy_cycles", DW'(busy_cnt), DW'(3));
        wait_drain();

        // Empty burst, NOP and illegal opcode, with stray data offered
        dat_valid = 1'b1;
        dat_in    = {DW{1'b1}};
        push_evt(K_DONE);
        send_cmd(3'd1, 11'h020, 8'd0);
        chk("len0_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("len0_dat_ready", DW'(dat_ready), '0);
        push_evt(K_ERR);
        send_cmd(3'd6, 11'h030, 8'd5);
        chk("illegal_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("illegal_busy", DW'(busy), '0);
        push_evt(K_DONE);
        send_cmd(3'd0, 11'h040, 8'd5);
        chk("nop_cmd_ready", DW'(cmd_ready), DW'(1));
        wait_drain();
        dat_valid = 1'b0;
        chk("stray_data_mem_hold", mem_in, exp_mem);

        // READ_OUT len 8 aborted by reset after the third beat
        for (int i = 0; i < 3; i++) push_beat(20'h10000 | 20'(11'h040 + 11'(i)), exp_mem);
        send_cmd(3'd4, 11'h040, 8'd8);
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("abort_three_beats", DW'(q.size()), '0);
        reset = 1'b1;
        #1;
        chk("abort_inst_async", DW'(inst), '0);
        chk("abort_busy", DW'(busy), '0);
        chk("abort_cmd_ready", DW'(cmd_ready), '0);
        exp_mem = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_idle_busy", DW'(busy), '0);
        chk("abort_idle_ready", DW'(cmd_ready), DW'(1));
        chk("abort_mem_cleared", mem_in, '0);

        // Back-to-back LOAD_K then EXEC: exactly one bubble between them
        trace.delete();
        trace_en = 1'b1;
        send_cmd(3'd1, 11'h300, 8'd2);
        data_phase(20'h80000, 11'h300, 2, 8'hFF, 1);
        run_cmd(3'd3, 20'h20000, 11'h010, 2);
        wait_drain();
        repeat (2) @(negedge clk);
        trace_en = 1'b0;
        last_k  = -1;
        first_e = -1;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i][19]) last_k = i;
            if (trace[i][17] && first_e < 0) first_e = i;
        end
        chk("b2b_gap", DW'(first_e - last_k), DW'(2));

        repeat (4) @(negedge clk);
        chk("final_queue_empty", DW'(q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_core_cmd_sequencer
`default_nettype wire
